// File: rtl/bfloat_16_mul.sv
// Initiator-side driver for the bfloat_16_mul start/strobe protocol: one multiply
// in flight, with result tag, timeout error flag and saturating latency count.
module bfloat_16_mul_driver #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  // Both handshakes are strict valid/ready: a transfer happens on a rising edge
  // where valid & ready are both high; valid never waits on ready.
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  input  logic [TAG_W-1:0] op_tag,
  output logic             mul_start,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  output logic             mul_a_stb,
  output logic             mul_b_stb,
  input  logic [15:0]      mul_z,
  input  logic             mul_z_stb,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_z,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic [15:0]      res_lat,
  output logic [1:0]       dbg_state
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [15:0]        z_q, z_d;
  logic               err_q, err_d;
  logic [15:0]        lat_q, lat_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               z_stb_q;
  logic               done;

  // Only a fresh rising edge counts; a done level left over from the previous
  // transaction must not complete this one.
  assign done = mul_z_stb & ~z_stb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
      lat_q   <= '0;
      timer_q <= '0;
      z_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      z_q     <= z_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
      timer_q <= timer_d;
      z_stb_q <= mul_z_stb;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    z_d     = z_q;
    err_d   = err_q;
    lat_d   = lat_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          tag_d   = op_tag;
          state_d = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        lat_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        lat_d   = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;
        // Completion takes priority over a timeout landing in the same cycle.
        if (done) begin
          z_d     = mul_z;
          err_d   = 1'b0;
          state_d = S_RESULT;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          z_d     = 16'hFFC0;
          err_d   = 1'b1;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs decode the state so an async reset drops them at once.
  assign op_ready  = (state_q == S_IDLE);
  assign mul_start = (state_q == S_START);
  assign mul_a_stb = (state_q == S_START) || (state_q == S_WAIT);
  assign mul_b_stb = mul_a_stb;
  assign res_valid = (state_q == S_RESULT);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign res_z     = z_q;
  assign res_tag   = tag_q;
  assign res_err   = err_q;
  assign res_lat   = lat_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bfloat_16_mul_driver.sv
// Directed + randomized bench for bfloat_16_mul_driver with a behavioural
// multiplier responder and a transaction-level expectation model.
module tb_bfloat_16_mul_driver;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             op_valid;
  logic             op_ready;
  logic [15:0]      op_a, op_b;
  logic [TAG_W-1:0] op_tag;
  logic             mul_start;
  logic [15:0]      mul_a, mul_b;
  logic             mul_a_stb, mul_b_stb;
  logic [15:0]      mul_z;
  logic             mul_z_stb;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_z;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic [15:0]      res_lat;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;

  // responder control: 0 = done after resp_dly cycles, 1 = stale level, 2 = never
  int resp_mode = 2;
  int resp_dly  = 1;
  int resp_cnt  = 0;
  bit resp_act  = 0;

  logic [15:0] exp_q[$];

  bfloat_16_mul_driver #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_tag(res_tag), .res_err(res_err), .res_lat(res_lat),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog expired");
  end

  // bfloat16 product of two normal numbers, mantissa truncated
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p;
    int          e;
    logic [6:0]  m;
    p = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    if (p[15]) begin
      m = p[14:8];
      e = e + 1;
    end else begin
      m = p[13:7];
    end
    return {a[15] ^ b[15], e[7:0], m};
  endfunction

  // multiplier model: counts cycles from the start pulse, drives a level done
  always @(negedge clk) begin
    if (!rst_n) begin
      mul_z_stb = 1'b0;
      mul_z     = 16'h0000;
      resp_act  = 0;
      resp_cnt  = 0;
    end else begin
      if (mul_start) begin
        resp_act = 1;
        resp_cnt = 0;
      end else if (resp_act) begin
        resp_cnt = resp_cnt + 1;
      end
      case (resp_mode)
        0:       mul_z_stb = resp_act && (resp_cnt >= resp_dly);
        1:       mul_z_stb = resp_act && (resp_cnt < 2 || resp_cnt >= 20);
        default: mul_z_stb = 1'b0;
      endcase
      mul_z = bf16_mul(mul_a, mul_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // present an operand pair at a negedge; returns at the negedge of START
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
    int n;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_tag   = tag;
    n = 0;
    while (!op_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("op_accept_wait", op_ready, 1);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // follow one transaction from START to its result handshake
  task automatic observe(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                         input int hold, input bit preload,
                         input logic [15:0] pa, input logic [15:0] pb, input logic [3:0] ptag);
    int          cyc;
    logic [15:0] ez, elat;
    logic        eerr;
    elat = exp_q.pop_front();
    eerr = exp_q.pop_front()[0];
    ez   = exp_q.pop_front();
    chk("start_pulse", mul_start, 1);
    chk("start_a", mul_a, a);
    chk("start_b", mul_b, b);
    chk("start_stbs", {mul_a_stb, mul_b_stb}, 2'b11);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!res_valid) begin
        chk("wait_start_low", mul_start, 0);
        chk("wait_stbs", {mul_a_stb, mul_b_stb}, 2'b11);
        chk("wait_op_ready", op_ready, 0);
      end
    end while (!res_valid && cyc < 300);
    chk("res_valid_cycle", cyc, 32'(elat) + 1);
    chk("res_z", res_z, ez);
    chk("res_tag", res_tag, tag);
    chk("res_err", res_err, eerr);
    chk("res_lat", res_lat, elat);
    chk("res_stbs_low", {mul_a_stb, mul_b_stb, mul_start}, 3'b000);
    if (preload) begin
      op_valid = 1'b1;
      op_a     = pa;
      op_b     = pb;
      op_tag   = ptag;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_op_ready", op_ready, 0);
      chk("hold_result", {res_z, res_tag, res_err, res_lat}, {ez, tag, eerr, elat});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("idle_op_ready", op_ready, 1);
    chk("idle_res_valid", res_valid, 0);
  endtask

  task automatic push_exp(input logic [15:0] lat, input logic err, input logic [15:0] z);
    exp_q.push_back(lat);
    exp_q.push_back({15'd0, err});
    exp_q.push_back(z);
  endtask

  function automatic logic [15:0] rand_bf16();
    logic [7:0] e;
    logic [6:0] m;
    e = 8'($urandom_range(110, 144));
    m = 7'($urandom_range(0, 127));
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  initial begin
    logic [15:0] a, b;
    logic [3:0]  t;
    int          d;

    // reset
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_tag    = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {mul_start, mul_a_stb, mul_b_stb, res_valid, res_err}, 5'b0);
    chk("rst_regs", {mul_a, mul_b, res_z, res_lat}, 64'(0));
    chk("rst_tag", res_tag, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_op_ready", op_ready, 1);

    // 1.0 x 2.0
    resp_mode = 0;
    resp_dly  = 5;
    push_exp(16'd5, 1'b0, 16'h4000);
    issue(16'h3F80, 16'h4000, 4'h5);
    observe(16'h3F80, 16'h4000, 4'h5, 0, 0, 16'h0, 16'h0, 4'h0);

    // -1.5 x 2.0
    resp_dly = 9;
    push_exp(16'd9, 1'b0, 16'hC040);
    issue(16'hBFC0, 16'h4000, 4'hA);
    observe(16'hBFC0, 16'h4000, 4'hA, 1, 0, 16'h0, 16'h0, 4'h0);

    // back-to-back with res_ready low for 10 cycles
    resp_dly = 3;
    push_exp(16'd3, 1'b0, 16'h4040);
    issue(16'h3FC0, 16'h4000, 4'h1);
    observe(16'h3FC0, 16'h4000, 4'h1, 10, 1, 16'h4080, 16'h4040, 4'h2);
    @(negedge clk);
    chk("b2b_accept_start", mul_start, 1);
    op_valid = 1'b0;
    push_exp(16'd3, 1'b0, bf16_mul(16'h4080, 16'h4040));
    observe(16'h4080, 16'h4040, 4'h2, 0, 0, 16'h0, 16'h0, 4'h0);

    // stale done level: only the later rise completes
    resp_mode = 1;
    push_exp(16'd20, 1'b0, bf16_mul(16'h4100, 16'hC000));
    issue(16'h4100, 16'hC000, 4'h7);
    observe(16'h4100, 16'hC000, 4'h7, 2, 0, 16'h0, 16'h0, 4'h0);

    // timeout: responder never completes
    resp_mode = 2;
    push_exp(16'(TIMEOUT), 1'b1, 16'hFFC0);
    issue(16'h3F80, 16'h3F80, 4'hC);
    observe(16'h3F80, 16'h3F80, 4'hC, 1, 0, 16'h0, 16'h0, 4'h0);

    // randomized latencies straddling the timeout boundary
    resp_mode = 0;
    for (int k = 0; k < 14; k++) begin
      a = rand_bf16();
      b = rand_bf16();
      t = 4'($urandom_range(0, 15));
      d = (k == 0) ? TIMEOUT : (k == 1) ? TIMEOUT + 1 : $urandom_range(1, TIMEOUT + 6);
      resp_dly = d;
      if (d <= TIMEOUT) push_exp(16'(d), 1'b0, bf16_mul(a, b));
      else              push_exp(16'(TIMEOUT), 1'b1, 16'hFFC0);
      issue(a, b, t);
      observe(a, b, t, $urandom_range(0, 3), 0, 16'h0, 16'h0, 4'h0);
    end

    // asynchronous reset in the middle of WAIT
    resp_mode = 2;
    issue(16'h4000, 16'h4000, 4'h3);
    repeat (6) @(negedge clk);
    chk("pre_rst_in_wait", {mul_a_stb, mul_b_stb}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_stbs", {mul_start, mul_a_stb, mul_b_stb}, 3'b000);
    chk("async_rst_valid", res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_op_ready", op_ready, 1);
    chk("post_rst_regs", {mul_a, res_lat}, 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
